// File: rtl/synth_pkg.sv
// Shared constants and encodings for the synth voice path.
package synth_pkg;

  localparam int unsigned NOTE_W             = 7;
  localparam int unsigned VEL_W              = 7;
  localparam int unsigned DEFAULT_NUM_VOICES = 4;
  localparam int unsigned DEFAULT_AGE_W      = 8;

  typedef enum logic [2:0] {
    AdsrAttack  = 3'd0,
    AdsrDecay   = 3'd1,
    AdsrSustain = 3'd2,
    AdsrRelease = 3'd3,
    AdsrQuick   = 3'd4,
    AdsrBlank   = 3'd5
  } adsr_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue
  } alloc_state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between the MIDI decoder (master) and the allocator (slave).
interface voice_allocator_if;
  import synth_pkg::*;

  logic              note_on_valid;
  logic              note_on_ready;
  logic              note_off_valid;
  logic              note_off_ready;
  logic [NOTE_W-1:0] note_num;
  logic [VEL_W-1:0]  velocity;

  modport master (
    output note_on_valid, note_off_valid, note_num, velocity,
    input  note_on_ready, note_off_ready
  );

  modport slave (
    input  note_on_valid, note_off_valid, note_num, velocity,
    output note_on_ready, note_off_ready
  );
endinterface

// File: rtl/voice_slot.sv
// Per-voice assignment record: note, velocity, key-held flag and saturating age.
module voice_slot
  import synth_pkg::*;
#(
  parameter int unsigned AGE_W = DEFAULT_AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [VEL_W-1:0]  load_vel,
  output logic [NOTE_W-1:0] note,
  output logic [VEL_W-1:0]  vel,
  output logic              held,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge clk) begin
    if (rst) begin
      note <= '0;
      vel  <= '0;
      held <= 1'b0;
      age  <= '0;
    end else if (load) begin
      note <= load_note;
      vel  <= load_vel;
      held <= 1'b1;
      age  <= '0;
    end else begin
      if (rel) held <= 1'b0;
      if (age_inc && (age != '1)) age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: serial scan of voices, then retrigger / free / steal on note-on
// and release of the matching voice on note-off.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int unsigned IDX_W      = $clog2(NUM_VOICES),
  parameter int unsigned AGE_W      = DEFAULT_AGE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  voice_allocator_if.slave             evt,
  input  logic [NUM_VOICES-1:0]        voice_idle,
  output logic [NUM_VOICES-1:0]        new_note_pulse,
  output logic [NUM_VOICES-1:0]        release_note_pulse,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_velocity,
  output logic [NUM_VOICES-1:0]        voice_held
);

  alloc_state_e      state_q;
  logic [IDX_W-1:0]  scan_idx_q;
  logic              evt_on_q;
  logic [NOTE_W-1:0] evt_note_q;
  logic [VEL_W-1:0]  evt_vel_q;
  logic              match_found_q, match_found_d, free_found_q, free_found_d;
  logic              unheld_found_q, unheld_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IDX_W-1:0]  unheld_idx_q, unheld_idx_d, all_idx_q, all_idx_d, target_idx;
  logic [AGE_W-1:0]  unheld_age_q, unheld_age_d, all_age_q, all_age_d;
  logic [NUM_VOICES-1:0] new_pulse_q, rel_pulse_q, target_oh, match_oh;
  logic [NUM_VOICES-1:0] slot_load, slot_rel, slot_age_inc;

  logic [NOTE_W-1:0] slot_note [NUM_VOICES];
  logic [VEL_W-1:0]  slot_vel  [NUM_VOICES];
  logic              slot_held [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];

  logic last, load_en, rel_en, off_acc, on_acc;

  assign evt.note_off_ready = (state_q == StIdle) && !rst;
  assign evt.note_on_ready  = evt.note_off_ready && !evt.note_off_valid;
  assign off_acc = evt.note_off_valid && evt.note_off_ready;
  assign on_acc  = evt.note_on_valid && evt.note_on_ready;

  // Running scan result including the voice visited this cycle.
  always_comb begin
    match_found_d  = match_found_q;
    match_idx_d    = match_idx_q;
    free_found_d   = free_found_q;
    free_idx_d     = free_idx_q;
    unheld_found_d = unheld_found_q;
    unheld_idx_d   = unheld_idx_q;
    unheld_age_d   = unheld_age_q;
    all_idx_d      = all_idx_q;
    all_age_d      = all_age_q;
    if (!match_found_q && slot_held[scan_idx_q] && (slot_note[scan_idx_q] == evt_note_q)) begin
      match_found_d = 1'b1;
      match_idx_d   = scan_idx_q;
    end
    if (!free_found_q && !slot_held[scan_idx_q] && voice_idle[scan_idx_q]) begin
      free_found_d = 1'b1;
      free_idx_d   = scan_idx_q;
    end
    if (!slot_held[scan_idx_q] && (!unheld_found_q || (slot_age[scan_idx_q] > unheld_age_q)))
    begin
      unheld_found_d = 1'b1;
      unheld_idx_d   = scan_idx_q;
      unheld_age_d   = slot_age[scan_idx_q];
    end
    if ((scan_idx_q == '0) || (slot_age[scan_idx_q] > all_age_q)) begin
      all_idx_d = scan_idx_q;
      all_age_d = slot_age[scan_idx_q];
    end

    if (match_found_d)       target_idx = match_idx_d;
    else if (free_found_d)   target_idx = free_idx_d;
    else if (unheld_found_d) target_idx = unheld_idx_d;
    else                     target_idx = all_idx_d;

    last    = (scan_idx_q == IDX_W'(NUM_VOICES - 1));
    load_en = (state_q == StScan) && last && evt_on_q;
    rel_en  = (state_q == StScan) && last && !evt_on_q && match_found_d;
    for (int i = 0; i < NUM_VOICES; i++) begin
      target_oh[i]    = (target_idx == IDX_W'(i));
      match_oh[i]     = (match_idx_d == IDX_W'(i));
      slot_load[i]    = load_en && target_oh[i];
      slot_age_inc[i] = load_en && !target_oh[i];
      slot_rel[i]     = rel_en && match_oh[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      scan_idx_q     <= '0;
      evt_on_q       <= 1'b0;
      evt_note_q     <= '0;
      evt_vel_q      <= '0;
      match_found_q  <= 1'b0;
      match_idx_q    <= '0;
      free_found_q   <= 1'b0;
      free_idx_q     <= '0;
      unheld_found_q <= 1'b0;
      unheld_idx_q   <= '0;
      unheld_age_q   <= '0;
      all_idx_q      <= '0;
      all_age_q      <= '0;
      new_pulse_q    <= '0;
      rel_pulse_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (off_acc || on_acc) begin
            // Velocity-0 note-on is a note-off.
            evt_on_q       <= on_acc && (evt.velocity != '0);
            evt_note_q     <= evt.note_num;
            evt_vel_q      <= evt.velocity;
            match_found_q  <= 1'b0;
            free_found_q   <= 1'b0;
            unheld_found_q <= 1'b0;
            scan_idx_q     <= '0;
            state_q        <= StScan;
          end
        end
        StScan: begin
          match_found_q  <= match_found_d;
          match_idx_q    <= match_idx_d;
          free_found_q   <= free_found_d;
          free_idx_q     <= free_idx_d;
          unheld_found_q <= unheld_found_d;
          unheld_idx_q   <= unheld_idx_d;
          unheld_age_q   <= unheld_age_d;
          all_idx_q      <= all_idx_d;
          all_age_q      <= all_age_d;
          if (last) begin
            new_pulse_q <= load_en ? target_oh : '0;
            rel_pulse_q <= rel_en ? match_oh : '0;
            state_q     <= StIssue;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        StIssue: begin
          new_pulse_q <= '0;
          rel_pulse_q <= '0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset in the issue cycle suppresses the pulse already registered.
  assign new_note_pulse     = new_pulse_q & {NUM_VOICES{!rst}};
  assign release_note_pulse = rel_pulse_q & {NUM_VOICES{!rst}};

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .AGE_W(AGE_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[i]),
      .rel       (slot_rel[i]),
      .age_inc   (slot_age_inc[i]),
      .load_note (evt_note_q),
      .load_vel  (evt_vel_q),
      .note      (slot_note[i]),
      .vel       (slot_vel[i]),
      .held      (slot_held[i]),
      .age       (slot_age[i])
    );
    assign voice_note[NOTE_W*i +: NOTE_W]   = slot_note[i];
    assign voice_velocity[VEL_W*i +: VEL_W] = slot_vel[i];
    assign voice_held[i]                    = slot_held[i];
  end

endmodule
